// File: rtl/spy_seq_pkg.sv
// spy_seq_pkg: state encoding and helpers shared by the
// spy readout sequencer and its event-list walker.
package spy_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SETTLE,
    META_RD,
    META_WAIT,
    DATA_RD,
    DATA_WAIT,
    DATA_OUT,
    HDR_OUT,
    DONE,
    ERR
  } state_t;

  // Sentinel flag sits just above the address field of a list entry
  function automatic int sentinel_bit(input int memwidth);
    return memwidth;
  endfunction

  function automatic int unsigned mod_len(
    input int unsigned e,
    input int unsigned s,
    input int unsigned w
  );
    return (e - s) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/spy_meta_walker.sv
// spy_meta_walker: scans the event list newest-first, skipping
// sentinels, to find the start/end addresses of one event.
module spy_meta_walker
  import spy_seq_pkg::*;
#(
  parameter int MEMWIDTH  = 6,
  parameter int METAWIDTH = 4
) (
  input  logic                 clock,
  input  logic                 resetbar,
  input  logic                 go,
  input  logic [METAWIDTH-1:0] mp,
  input  logic [METAWIDTH-1:0] idx,
  output logic                 meta_read_enable,
  output logic [METAWIDTH-1:0] meta_read_addr,
  input  logic [MEMWIDTH:0]    meta_read_data,
  output logic [MEMWIDTH-1:0]  start_addr,
  output logic [MEMWIDTH-1:0]  end_addr,
  output logic                 valid,
  output logic                 err
);

  localparam int SBIT = sentinel_bit(MEMWIDTH);
  localparam logic [METAWIDTH:0] LAST = {1'b0, {METAWIDTH{1'b1}}};

  state_t               st;
  logic [METAWIDTH-1:0] ptr;
  logic [METAWIDTH:0]   walked;
  logic [METAWIDTH:0]   found;
  logic                 sentinel;
  logic [MEMWIDTH-1:0]  addr;
  logic                 hit;

  assign sentinel = meta_read_data[SBIT];
  assign addr     = meta_read_data[MEMWIDTH-1:0];
  assign hit      = !sentinel &&
                    (found == ({1'b0, idx} + 1'b1));

  always_ff @(posedge clock or negedge resetbar) begin
    if (!resetbar) begin
      st               <= IDLE;
      ptr              <= '0;
      walked           <= '0;
      found            <= '0;
      meta_read_enable <= 1'b0;
      meta_read_addr   <= '0;
      start_addr       <= '0;
      end_addr         <= '0;
      valid            <= 1'b0;
      err              <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      unique case (st)
        IDLE: begin
          if (go) begin
            ptr              <= mp - 1'b1;
            walked           <= '0;
            found            <= '0;
            meta_read_enable <= 1'b1;
            meta_read_addr   <= mp - 1'b1;
            st               <= META_RD;
          end
        end
        META_RD: begin
          meta_read_enable <= 1'b0;
          st               <= META_WAIT;
        end
        META_WAIT: begin
          if (hit) begin
            start_addr <= addr;
            valid      <= 1'b1;
            st         <= IDLE;
          end else begin
            // Younger SOEs bound the end of the event below them
            if (!sentinel) begin
              end_addr <= addr;
              found    <= found + 1'b1;
            end
            ptr    <= ptr - 1'b1;
            walked <= walked + 1'b1;
            if (walked == LAST) begin
              err <= 1'b1;
              st  <= IDLE;
            end else begin
              meta_read_enable <= 1'b1;
              meta_read_addr   <= ptr - 1'b1;
              st               <= META_RD;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/spy_readout_sequencer.sv
// spy_readout_sequencer: freezes the spy buffer, locates one event
// and streams it out. SPY_READOUT_HEADER_EN adds a leading header word.
module spy_readout_sequencer
  import spy_seq_pkg::*;
#(
  parameter int DATAWIDTH     = 64,
  parameter int MEMWIDTH      = 6,
  parameter int METAWIDTH     = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 resetbar,
  input  logic                 req,
  input  logic [METAWIDTH-1:0] req_index,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 freeze,
  input  logic [MEMWIDTH-1:0]  mem_wptr,
  input  logic [METAWIDTH-1:0] meta_write_addr,
  output logic                 meta_read_enable,
  output logic [METAWIDTH-1:0] meta_read_addr,
  input  logic [MEMWIDTH:0]    meta_read_data,
  output logic                 read_enable,
  output logic [MEMWIDTH-1:0]  read_addr,
  input  logic [DATAWIDTH:0]   data_out,
  output logic [DATAWIDTH:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  state_t               state;
  logic [METAWIDTH-1:0] idx;
  logic [3:0]           cnt;
  logic [MEMWIDTH-1:0]  wp;
  logic [MEMWIDTH-1:0]  raddr;
  logic [MEMWIDTH-1:0]  end_r;
  logic                 walk_go;
  logic                 walk_valid;
  logic                 walk_err;
  logic [MEMWIDTH-1:0]  w_start;
  logic [MEMWIDTH-1:0]  w_end;
  logic [MEMWIDTH-1:0]  len;
  logic                 unused_wp;

  assign walk_go = (state == SETTLE) &&
                   (cnt == 4'(SETTLE_CYCLES - 1));
  assign len = MEMWIDTH'(mod_len(32'(w_end), 32'(w_start),
                                 MEMWIDTH));
  assign unused_wp = ^wp;

`ifdef SPY_READOUT_HEADER_EN
  logic [DATAWIDTH:0] hdr;
  always_comb begin
    hdr = '0;
    hdr[MEMWIDTH-1:0] = len;
    hdr[MEMWIDTH +: METAWIDTH] = idx;
  end
`endif

  spy_meta_walker #(
    .MEMWIDTH (MEMWIDTH),
    .METAWIDTH(METAWIDTH)
  ) u_walker (
    .clock           (clock),
    .resetbar        (resetbar),
    .go              (walk_go),
    .mp              (meta_write_addr),
    .idx             (idx),
    .meta_read_enable(meta_read_enable),
    .meta_read_addr  (meta_read_addr),
    .meta_read_data  (meta_read_data),
    .start_addr      (w_start),
    .end_addr        (w_end),
    .valid           (walk_valid),
    .err             (walk_err)
  );

  always_ff @(posedge clock or negedge resetbar) begin
    if (!resetbar) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      wp          <= '0;
      raddr       <= '0;
      end_r       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      freeze      <= 1'b0;
      read_enable <= 1'b0;
      read_addr   <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            idx    <= req_index;
            cnt    <= '0;
            busy   <= 1'b1;
            freeze <= 1'b1;
            state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (walk_go) begin
            wp    <= mem_wptr;
            state <= META_RD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        META_RD: begin
          if (walk_err || (walk_valid && len == '0)) begin
            error  <= 1'b1;
            freeze <= 1'b0;
            busy   <= 1'b0;
            state  <= ERR;
          end else if (walk_valid) begin
            raddr <= w_start;
            end_r <= w_end;
`ifdef SPY_READOUT_HEADER_EN
            out_data  <= hdr;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            state     <= HDR_OUT;
`else
            read_enable <= 1'b1;
            read_addr   <= w_start;
            state       <= DATA_RD;
`endif
          end
        end
        HDR_OUT: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            read_enable <= 1'b1;
            read_addr   <= raddr;
            state       <= DATA_RD;
          end
        end
        DATA_RD: begin
          read_enable <= 1'b0;
          state       <= DATA_WAIT;
        end
        DATA_WAIT: begin
          out_data  <= data_out;
          out_valid <= 1'b1;
          out_last  <= (raddr + 1'b1) == end_r;
          state     <= DATA_OUT;
        end
        DATA_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            raddr     <= raddr + 1'b1;
            if (out_last) begin
              done   <= 1'b1;
              freeze <= 1'b0;
              busy   <= 1'b0;
              state  <= DONE;
            end else begin
              read_enable <= 1'b1;
              read_addr   <= raddr + 1'b1;
              state       <= DATA_RD;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          error <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spy_readout_sequencer.sv
// tb_spy_readout_sequencer: directed dumps against memory models,
// expected words queued at request time and popped on handshake.
module tb_spy_readout_sequencer;

  localparam int DW = 64;
  localparam int MW = 6;
  localparam int XW = 4;
  localparam int W  = DW + 1;

  logic          clock = 1'b0;
  logic          resetbar = 1'b1;
  logic          req = 1'b0;
  logic [XW-1:0] req_index = '0;
  logic          busy, done, error, freeze;
  logic [MW-1:0] mem_wptr = '0;
  logic [XW-1:0] meta_write_addr = '0;
  logic          meta_read_enable;
  logic [XW-1:0] meta_read_addr;
  logic [MW:0]   meta_read_data = '0;
  logic          read_enable;
  logic [MW-1:0] read_addr;
  logic [DW:0]   data_out = '0;
  logic [DW:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;

  logic [DW:0]   spy [64];
  logic [MW:0]   meta [16];
  logic [DW:0]   exp_q [$];
  int            ncmp = 0;
  int            nbad = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (read_enable) data_out <= spy[read_addr];
    if (meta_read_enable) meta_read_data <= meta[meta_read_addr];
  end

  spy_readout_sequencer dut (
    .clock           (clock),
    .resetbar        (resetbar),
    .req             (req),
    .req_index       (req_index),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .freeze          (freeze),
    .mem_wptr        (mem_wptr),
    .meta_write_addr (meta_write_addr),
    .meta_read_enable(meta_read_enable),
    .meta_read_addr  (meta_read_addr),
    .meta_read_data  (meta_read_data),
    .read_enable     (read_enable),
    .read_addr       (read_addr),
    .data_out        (data_out),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_last        (out_last)
  );

  task automatic check(input string tag, input logic [DW:0] got,
                       input logic [DW:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nbad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_meta();
    for (int i = 0; i < 16; i++) meta[i] = {1'b1, 6'd0};
  endtask

  task automatic soe(input int i, input int a);
    meta[i] = {1'b0, 6'(a)};
  endtask

  task automatic push(input int idx, input int s, input int n);
`ifdef SPY_READOUT_HEADER_EN
    logic [DW:0] h = '0;
    h[MW-1:0] = MW'(n);
    h[MW +: XW] = XW'(idx);
    exp_q.push_back(h);
`endif
    for (int i = 0; i < n; i++) exp_q.push_back(spy[(s + i) % 64]);
  endtask

  task automatic dump(input string tag, input int idx,
                      input int stall_at, input bit exp_err,
                      input int exp_reads);
    int words = 0;
    int cyc = 0;
    int stall = 0;
    int reads = 0;
    bit fz_bad = 0;
    bit seen_valid = 0;
    bit fin = 0;
    bit got_err = 0;
    logic [DW:0] snap = '0;
    logic [DW:0] w;
    @(negedge clock);
    req = 1'b1;
    req_index = XW'(idx);
    out_ready = 1'b1;
    @(negedge clock);
    req = 1'b0;
    while (!fin && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      if (busy && !freeze) fz_bad = 1;
      if (meta_read_enable) reads++;
      if (done || error) begin
        fin = 1;
        got_err = error;
      end else begin
        if (out_valid) seen_valid = 1;
        if (out_valid && stall == 0 && words == stall_at) begin
          stall = 1;
          snap = out_data;
          out_ready = 1'b0;
        end else if (stall >= 1 && stall <= 10) begin
          check({tag, "_hold_data"}, out_data, snap);
          check({tag, "_hold_valid"}, W'(out_valid), W'(1));
          stall++;
          if (stall == 11) out_ready = 1'b1;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check({tag, "_extra_word"}, out_data, '0);
          end else begin
            w = exp_q.pop_front();
            check({tag, "_data"}, out_data, w);
            check({tag, "_last"}, W'(out_last), W'(exp_q.size() == 0));
          end
          words++;
        end
      end
    end
    check({tag, "_finished"}, W'(fin), W'(1));
    check({tag, "_error"}, W'(got_err), W'(exp_err));
    check({tag, "_left"}, W'(exp_q.size()), W'(0));
    check({tag, "_freeze_held"}, W'(fz_bad), W'(0));
    check({tag, "_released"}, W'({busy, freeze}), W'(0));
    check({tag, "_meta_reads"}, W'(reads), W'(exp_reads));
    if (exp_err) check({tag, "_no_valid"}, W'(seen_valid), W'(0));
    exp_q.delete();
  endtask

  task automatic setup_a();
    clear_meta();
    soe(0, 5);
    soe(1, 12);
    soe(2, 20);
    meta_write_addr = 4'd3;
    mem_wptr = 6'd25;
  endtask

  initial begin
    int cyc;
    for (int a = 0; a < 64; a++)
      spy[a] = {1'(a % 2), 32'hC0DE_0000 + 32'(a), 32'(a * 7 + 3)};
    clear_meta();

    #2 resetbar = 1'b0;
    #1;
    check("reset_ctl",
          W'({busy, done, error, freeze, out_valid, out_last,
              read_enable, meta_read_enable}), W'(0));
    check("reset_data", out_data, '0);
    repeat (3) @(negedge clock);
    resetbar = 1'b1;

    setup_a();
    push(0, 12, 8);
    dump("ev0", 0, -1, 1'b0, 2);
    push(1, 5, 7);
    dump("ev1", 1, -1, 1'b0, 3);
    push(0, 12, 8);
    dump("stall", 0, 3, 1'b0, 2);
    dump("miss", 7, -1, 1'b1, 16);

    clear_meta();
    soe(0, 60);
    soe(2, 3);
    soe(3, 9);
    meta_write_addr = 4'd4;
    push(1, 60, 7);
    dump("wrap", 1, -1, 1'b0, 4);

    clear_meta();
    soe(1, 30);
    soe(2, 30);
    meta_write_addr = 4'd3;
    dump("len0", 0, -1, 1'b1, 2);

    setup_a();
    @(negedge clock);
    out_ready = 1'b0;
    req = 1'b1;
    req_index = '0;
    @(negedge clock);
    req = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    check("rst_reach_out", W'(out_valid), W'(1));
    #2 resetbar = 1'b0;
    #1;
    check("rst_mid", W'({busy, freeze, out_valid}), W'(0));
    @(negedge clock);
    resetbar = 1'b1;
    push(0, 12, 8);
    dump("after_rst", 0, -1, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
